dmem_bridge: RTL and testbench

//  Sits between the single-cycle mips core's data port (mem_adr/mem_out/mem_read/mem_write/mem_in)
//  and a multi-cycle data-memory bus with req/ack handshake. Freezes the core with cpu_stall

---
 rtl/dmem_bridge.sv | 164 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_bridge                                                    |
// | Purpose : Adapts the single-cycle core data port to a multi-cycle        |
// |           req/ack data-memory bus. Stalls the core while an access is    |
// |           outstanding, returns load data and flags misaligned or         |
// |           timed-out accesses.                                            |
// | Ports   : clk, rst          - clock, synchronous active-high reset       |
// |           cpu_adr/wdata     - core byte address / store data             |
// |           cpu_read/write    - core load / store request                  |
// |           cpu_rdata         - registered load data to core               |
// |           cpu_stall         - core hold request                          |
// |           bus_req/we/adr/wdata - registered bus request side             |
// |           bus_rdata/ack     - bus response                               |
// |           err, err_adr      - sticky error flag, first failing address   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_bridge #(
   parameter int          DATA_W   = 32,
   parameter int          TIMEOUT  = 15,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_read,
   input  logic              cpu_write,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              bus_req,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_adr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              err,
   output logic [DATA_W-1:0] err_adr
);

   localparam int                C_CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT);
   localparam logic [DATA_W-1:0]  C_ERR     = DATA_W'(ERR_DATA);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [C_CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   err_adr_q, err_adr_d;

   logic w_req;
   logic w_misaligned;
   logic w_load;

   assign w_req        = cpu_read | cpu_write;
   assign w_misaligned = |cpu_adr[1:0];
   // A combined read+write request is treated as a store.
   assign w_load       = cpu_read & ~cpu_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rdata_q   <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         err_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         req_q     <= req_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         err_adr_q <= err_adr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      req_d     = req_q;
      we_d      = we_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      err_adr_d = err_adr_q;
      cpu_stall = 1'b0;

      case (state_q)
         S_IDLE: begin
            cpu_stall = w_req & ~rst;
            if (w_req) begin
               if (w_misaligned) begin
                  // Rejected without touching the bus; only the first
                  // failing address is captured.
                  err_d = 1'b1;
                  if (!err_q) err_adr_d = cpu_adr;
                  if (w_load) rdata_d = C_ERR;
                  state_d = S_DONE;
               end else begin
                  adr_d   = cpu_adr;
                  wdata_d = cpu_wdata;
                  we_d    = cpu_write;
                  req_d   = 1'b1;
                  cnt_d   = C_CNT_W'(1);
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            cpu_stall = ~rst;
            if (bus_ack) begin
               // An ack in the final allowed cycle still wins over timeout.
               if (!we_q) rdata_d = bus_rdata;
               req_d   = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == C_TIMEOUT) begin
               req_d = 1'b0;
               err_d = 1'b1;
               if (!err_q) err_adr_d = adr_q;
               if (!we_q) rdata_d = C_ERR;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         S_DONE: begin
            // Core completes the instruction at this edge; no new access here.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign cpu_rdata = rdata_q;
   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_adr   = adr_q;
   assign bus_wdata = wdata_q;
   assign err       = err_q;
   assign err_adr   = err_adr_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dmem_bridge                                                 |
// | Purpose : Directed self-checking bench for dmem_bridge.                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] cpu_adr;
   logic [31:0] cpu_wdata;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_adr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        err;
   logic [31:0] err_adr;

   int checks   = 0;
   int failures = 0;
   int n;
   int stalls;

   dmem_bridge #(
      .DATA_W   (32),
      .TIMEOUT  (15),
      .ERR_DATA (32'hDEADBEEF)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_adr   (cpu_adr),
      .cpu_wdata (cpu_wdata),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_adr   (bus_adr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .err       (err),
      .err_adr   (err_adr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      cpu_adr   = '0;
      cpu_wdata = '0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      bus_rdata = '0;
      bus_ack   = 1'b0;

      // ---------------- reset state ----------------
      tick(); tick();
      cpu_read = 1'b1; cpu_adr = 32'h40;
      #1;
      chk("rst_stall_forced0", {31'd0, cpu_stall}, 32'd0);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_adr", err_adr, 32'd0);
      chk("rst_bus_adr", bus_adr, 32'd0);
      cpu_read = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // ---------------- load 0x40, ack in first REQ cycle ----------------
      cpu_read = 1'b1; cpu_adr = 32'h40;
      #1;
      chk("ld_idle_stall", {31'd0, cpu_stall}, 32'd1);
      tick();
      chk("ld_req", {31'd0, bus_req}, 32'd1);
      chk("ld_we", {31'd0, bus_we}, 32'd0);
      chk("ld_adr", bus_adr, 32'h40);
      chk("ld_req_stall", {31'd0, cpu_stall}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
      chk("ld_done_stall", {31'd0, cpu_stall}, 32'd0);
      chk("ld_done_rdata", cpu_rdata, 32'h1234_5678);
      chk("ld_done_req", {31'd0, bus_req}, 32'd0);
      chk("ld_done_err", {31'd0, err}, 32'd0);
      cpu_read = 1'b0;
      tick();

      // ---------------- store 0xAB to 0x80, ack in 3rd REQ cycle ----------------
      cpu_write = 1'b1; cpu_adr = 32'h80; cpu_wdata = 32'hAB;
      #1;
      stalls = cpu_stall ? 1 : 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (cpu_stall) stalls++;
         chk("st_req", {31'd0, bus_req}, 32'd1);
         chk("st_we", {31'd0, bus_we}, 32'd1);
         chk("st_adr", bus_adr, 32'h80);
         chk("st_wdata", bus_wdata, 32'hAB);
         if (i == 3) bus_ack = 1'b1;
      end
      tick();
      bus_ack = 1'b0;
      chk("st_stall_cycles", stalls, 32'd4);
      chk("st_done_stall", {31'd0, cpu_stall}, 32'd0);
      chk("st_rdata_kept", cpu_rdata, 32'h1234_5678);
      cpu_write = 1'b0;
      tick();

      // ---------------- misaligned load 0x42 ----------------
      cpu_read = 1'b1; cpu_adr = 32'h42;
      #1;
      chk("mis_idle_stall", {31'd0, cpu_stall}, 32'd1);
      tick();
      chk("mis_req", {31'd0, bus_req}, 32'd0);
      chk("mis_stall", {31'd0, cpu_stall}, 32'd0);
      chk("mis_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("mis_err", {31'd0, err}, 32'd1);
      chk("mis_err_adr", err_adr, 32'h42);
      cpu_read = 1'b0;
      tick();
      chk("mis_after_req", {31'd0, bus_req}, 32'd0);

      // ---------------- load 0x100, no ack -> timeout ----------------
      cpu_read = 1'b1; cpu_adr = 32'h100;
      n = 0;
      tick();
      while (bus_req && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", n, 32'd15);
      chk("to_stall", {31'd0, cpu_stall}, 32'd0);
      chk("to_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_err_adr_kept", err_adr, 32'h42);
      cpu_read = 1'b0;
      tick();

      // ---------------- load 0x200, ack in 15th REQ cycle -> success ----------------
      cpu_read = 1'b1; cpu_adr = 32'h200;
      tick();
      for (int i = 1; i < 15; i++) tick();
      chk("ack15_req", {31'd0, bus_req}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
      chk("ack15_rdata", cpu_rdata, 32'h0BAD_F00D);
      chk("ack15_req_off", {31'd0, bus_req}, 32'd0);
      chk("ack15_err_adr", err_adr, 32'h42);
      cpu_read = 1'b0;
      tick();

      // ---------------- reset in 2nd REQ cycle ----------------
      cpu_read = 1'b1; cpu_adr = 32'h300;
      tick();
      tick();
      chk("rstm_req", {31'd0, bus_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstm_stall", {31'd0, cpu_stall}, 32'd0);
      tick();
      rst = 1'b0; cpu_read = 1'b0;
      chk("rstm_req_off", {31'd0, bus_req}, 32'd0);
      chk("rstm_rdata", cpu_rdata, 32'd0);
      chk("rstm_err", {31'd0, err}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
      chk("late_ack_req", {31'd0, bus_req}, 32'd0);
      chk("late_ack_rdata", cpu_rdata, 32'd0);
      chk("late_ack_stall", {31'd0, cpu_stall}, 32'd0);

      // ---------------- simultaneous read+write at 0x8 ----------------
      cpu_read = 1'b1; cpu_write = 1'b1; cpu_adr = 32'h8; cpu_wdata = 32'h77;
      tick();
      chk("rw_req", {31'd0, bus_req}, 32'd1);
      chk("rw_we", {31'd0, bus_we}, 32'd1);
      chk("rw_adr", bus_adr, 32'h8);
      chk("rw_wdata", bus_wdata, 32'h77);
      bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
      chk("rw_rdata_kept", cpu_rdata, 32'd0);
      chk("rw_stall", {31'd0, cpu_stall}, 32'd0);
      cpu_read = 1'b0; cpu_write = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
